// File: rtl/reg_scoreboard_pkg.sv
// Shared types and defaults for the register scoreboard.
// Index width, register count and zero-register position.
package reg_scoreboard_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int N_REGS_DEF = 32;
  localparam int ZR_IDX_DEF = 31;
  localparam int CNT_W_DEF  = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  function automatic logic idx_hit(reg_idx_t a, int unsigned i);
    return a == reg_idx_t'(i);
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_cnt.sv
// One saturating up/down pending-write counter.
// Clear overrides; inc+dec together hold the count.
module sb_cnt
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             full,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nz_q, nz_d;

  // next count: clear first, then net inc/dec with saturation
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q != MAX) cnt_d = cnt_q + ONE;
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_d = cnt_q - ONE;
    end
    nz_d = (cnt_d != '0);
  end

  // count register and its registered nonzero flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      nz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      nz_q  <= nz_d;
    end
  end

  assign cnt       = cnt_q;
  assign nonzero   = nz_q;
  assign full      = (cnt_q == MAX);
  assign underflow = dec && (cnt_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-stage register scoreboard: RAW / full-counter stalls.
// Optional stall statistics under REG_SCOREBOARD_STATS_EN.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ZR_IDX = ZR_IDX_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_ra1,
  input  logic [REG_IDX_W-1:0] issue_ra2,
  input  logic                 issue_use1,
  input  logic                 issue_use2,
  input  logic                 issue_we,
  input  logic [REG_IDX_W-1:0] issue_wa,
  output logic                 stall,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_wa,
  input  logic                 clear,
  output logic [N_REGS-1:0]    busy_vec,
`ifdef REG_SCOREBOARD_STATS_EN
  output logic [31:0]          stall_cycles,
`endif
  output logic                 err
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam reg_idx_t         ZR  = reg_idx_t'(ZR_IDX);

  logic [CNT_W-1:0] cnt_w [N_REGS];
  logic [N_REGS-1:0] nz_w;
  logic [N_REGS-1:0] full_w;
  logic [N_REGS-1:0] unf_w;

  logic [CNT_W-1:0] cnt_ra1, cnt_ra2;
  logic busy1, busy2, wfull, accept;
  logic err_q, err_d;

  assign cnt_ra1 = cnt_w[issue_ra1];
  assign cnt_ra2 = cnt_w[issue_ra2];

  // a final retire to the same index is bypassed by the regfile
  assign busy1 = (cnt_ra1 != '0)
              && !(wb_we && (wb_wa == issue_ra1)
                   && (cnt_ra1 == ONE));
  assign busy2 = (cnt_ra2 != '0)
              && !(wb_we && (wb_wa == issue_ra2)
                   && (cnt_ra2 == ONE));

  assign wfull = issue_we && (issue_wa != ZR)
              && full_w[issue_wa]
              && !(wb_we && (wb_wa == issue_wa));

  assign stall = issue_valid
              && ((issue_use1 && busy1)
               || (issue_use2 && busy2)
               || wfull);

  assign accept = issue_valid && !stall;

  for (genvar i = 0; i < N_REGS; i++) begin : g_reg
    if (i == ZR_IDX) begin : g_zr
      assign cnt_w[i]  = '0;
      assign nz_w[i]   = 1'b0;
      assign full_w[i] = 1'b0;
      assign unf_w[i]  = 1'b0;
    end else begin : g_cnt
      logic inc, dec;
      assign inc = accept && issue_we
                && idx_hit(issue_wa, i);
      assign dec = wb_we && idx_hit(wb_wa, i);
      sb_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc),
        .dec       (dec),
        .clr       (clear),
        .cnt       (cnt_w[i]),
        .nonzero   (nz_w[i]),
        .full      (full_w[i]),
        .underflow (unf_w[i])
      );
    end
  end

  // sticky underflow error, cleared only by reset
  always_comb begin
    err_d = err_q | (|unf_w);
  end

  // error flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err      = err_q;
  assign busy_vec = nz_w;

`ifdef REG_SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // saturating count of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // stall statistics register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
